// File: rtl/csr_regfile.sv
// Machine-mode CSR register file at the tail of the ID->EX CSR path.
// EX commits read-modify-write commands (RW/RS/RC); ID reads combinationally with
// a same-cycle bypass of the committing write. Optional build macro CSR_COUNTERS_EN
// adds the 64-bit mcycle/minstret counters.
module csr_regfile #(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MTVEC_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] csr_read_addr_ID,
  output logic [31:0] csr_out_ID,
  output logic        csr_illegal_ID,
  input  logic [1:0]  Mask_func_EX,
  input  logic        csr_write_en_EX,
  input  logic [11:0] csr_dest_EX,
  input  logic [31:0] reg1_or_zimm_EX,
  input  logic        instr_retire
);

  localparam logic [11:0] AddrMstatus  = 12'h300;
  localparam logic [11:0] AddrMie      = 12'h304;
  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
  localparam logic [11:0] AddrMtval    = 12'h343;
  localparam logic [11:0] AddrMip      = 12'h344;
  localparam logic [11:0] AddrMhartid  = 12'hF14;
  localparam logic [11:0] AddrMcycle   = 12'hB00;
  localparam logic [11:0] AddrMcycleh  = 12'hB80;
  localparam logic [11:0] AddrMinstret = 12'hB02;
  localparam logic [11:0] AddrMinstreth = 12'hB82;

  localparam logic [31:0] MipWrMask = 32'h0000_0888;

  logic [31:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d, mip_q, mip_d;

  logic [31:0] rd_val, wr_old, wr_raw, wr_new;
  logic        rd_ok, wr_ok, commit;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
`else
  logic unused_instr_retire;
  assign unused_instr_retire = instr_retire;
`endif

  // Decode the ID read address into stored value and legality.
  always_comb begin
    rd_val = 32'h0;
    rd_ok  = 1'b1;
    case (csr_read_addr_ID)
      AddrMstatus:   rd_val = mstatus_q;
      AddrMie:       rd_val = mie_q;
      AddrMtvec:     rd_val = mtvec_q;
      AddrMscratch:  rd_val = mscratch_q;
      AddrMepc:      rd_val = mepc_q;
      AddrMcause:    rd_val = mcause_q;
      AddrMtval:     rd_val = mtval_q;
      AddrMip:       rd_val = mip_q;
      AddrMhartid:   rd_val = HART_ID;
`ifdef CSR_COUNTERS_EN
      AddrMcycle:    rd_val = mcycle_q[31:0];
      AddrMcycleh:   rd_val = mcycle_q[63:32];
      AddrMinstret:  rd_val = minstret_q[31:0];
      AddrMinstreth: rd_val = minstret_q[63:32];
`endif
      default:       rd_ok  = 1'b0;
    endcase
  end

  // Decode the EX target: old value, writability, RMW result and per-CSR field mask.
  always_comb begin
    wr_old = 32'h0;
    wr_ok  = 1'b1;
    case (csr_dest_EX)
      AddrMstatus:   wr_old = mstatus_q;
      AddrMie:       wr_old = mie_q;
      AddrMtvec:     wr_old = mtvec_q;
      AddrMscratch:  wr_old = mscratch_q;
      AddrMepc:      wr_old = mepc_q;
      AddrMcause:    wr_old = mcause_q;
      AddrMtval:     wr_old = mtval_q;
      AddrMip:       wr_old = mip_q;
`ifdef CSR_COUNTERS_EN
      AddrMcycle:    wr_old = mcycle_q[31:0];
      AddrMcycleh:   wr_old = mcycle_q[63:32];
      AddrMinstret:  wr_old = minstret_q[31:0];
      AddrMinstreth: wr_old = minstret_q[63:32];
`endif
      default:       wr_ok  = 1'b0; // unimplemented or read-only (mhartid)
    endcase

    case (Mask_func_EX)
      2'b01:   wr_raw = reg1_or_zimm_EX;
      2'b10:   wr_raw = wr_old | reg1_or_zimm_EX;
      2'b11:   wr_raw = wr_old & ~reg1_or_zimm_EX;
      default: wr_raw = wr_old;
    endcase

    case (csr_dest_EX)
      AddrMepc:  wr_new = {wr_raw[31:2], 2'b00};
      AddrMtvec: wr_new = {wr_raw[31:2], 1'b0, wr_raw[0]};
      AddrMip:   wr_new = wr_raw & MipWrMask;
      default:   wr_new = wr_raw;
    endcase

    commit = csr_write_en_EX && (Mask_func_EX != 2'b00) && wr_ok;
  end

  // Read port with bypass of the write committing this cycle.
  always_comb begin
    csr_illegal_ID = ~rd_ok;
    csr_out_ID     = rd_val;
    if (commit && (csr_read_addr_ID == csr_dest_EX)) begin
      csr_out_ID = wr_new;
    end
  end

  // Next-state for the plain CSRs and counters; explicit writes beat increments per half.
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mip_d      = mip_q;
`ifdef CSR_COUNTERS_EN
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = instr_retire ? (minstret_q + 64'd1) : minstret_q;
`endif
    if (commit) begin
      case (csr_dest_EX)
        AddrMstatus:   mstatus_d  = wr_new;
        AddrMie:       mie_d      = wr_new;
        AddrMtvec:     mtvec_d    = wr_new;
        AddrMscratch:  mscratch_d = wr_new;
        AddrMepc:      mepc_d     = wr_new;
        AddrMcause:    mcause_d   = wr_new;
        AddrMtval:     mtval_d    = wr_new;
        AddrMip:       mip_d      = wr_new;
`ifdef CSR_COUNTERS_EN
        AddrMcycle:    mcycle_d[31:0]    = wr_new;
        AddrMcycleh:   mcycle_d[63:32]   = wr_new;
        AddrMinstret:  minstret_d[31:0]  = wr_new;
        AddrMinstreth: minstret_d[63:32] = wr_new;
`endif
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset taking priority over all updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_q  <= 32'h0;
      mie_q      <= 32'h0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
      mip_q      <= 32'h0;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
`endif
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mip_q      <= mip_d;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
`endif
    end
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Directed self-checking bench for csr_regfile; counter checks follow CSR_COUNTERS_EN.
module tb_csr_regfile;

  localparam logic [31:0] HartId   = 32'h0000_00A7;
  localparam logic [31:0] MtvecRst = 32'h8000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_read_addr_ID;
  logic [31:0] csr_out_ID;
  logic        csr_illegal_ID;
  logic [1:0]  Mask_func_EX;
  logic        csr_write_en_EX;
  logic [11:0] csr_dest_EX;
  logic [31:0] reg1_or_zimm_EX;
  logic        instr_retire;

  int n_tests = 0;
  int n_fail  = 0;

  csr_regfile #(
    .HART_ID   (HartId),
    .MTVEC_RST (MtvecRst)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .csr_read_addr_ID (csr_read_addr_ID),
    .csr_out_ID       (csr_out_ID),
    .csr_illegal_ID   (csr_illegal_ID),
    .Mask_func_EX     (Mask_func_EX),
    .csr_write_en_EX  (csr_write_en_EX),
    .csr_dest_EX      (csr_dest_EX),
    .reg1_or_zimm_EX  (reg1_or_zimm_EX),
    .instr_retire     (instr_retire)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one EX command across a single posedge, then return the EX port to idle.
  task automatic ex_cmd(input logic [1:0] func, input logic en, input logic [11:0] addr,
                        input logic [31:0] op);
    @(negedge clk);
    Mask_func_EX    = func;
    csr_write_en_EX = en;
    csr_dest_EX     = addr;
    reg1_or_zimm_EX = op;
    @(posedge clk);
    #1;
    Mask_func_EX    = 2'b00;
    csr_write_en_EX = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [11:0] addr, input logic [31:0] exp,
                          input logic exp_ill);
    csr_read_addr_ID = addr;
    #1;
    check_eq(tag, csr_out_ID, exp);
    check_eq({tag, "_ill"}, {31'd0, csr_illegal_ID}, {31'd0, exp_ill});
  endtask

  initial begin
    rst_n            = 1'b0;
    csr_read_addr_ID = 12'h000;
    Mask_func_EX     = 2'b01;
    csr_write_en_EX  = 1'b1;
    csr_dest_EX      = 12'h340;
    reg1_or_zimm_EX  = 32'hFFFF_FFFF; // reset must win over this pending write
    instr_retire     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    Mask_func_EX    = 2'b00;
    csr_write_en_EX = 1'b0;
    rst_n           = 1'b1;

    // Reset values
    rd_check("rst_mstatus",  12'h300, 32'h0, 1'b0);
    rd_check("rst_mie",      12'h304, 32'h0, 1'b0);
    rd_check("rst_mtvec",    12'h305, MtvecRst, 1'b0);
    rd_check("rst_mscratch", 12'h340, 32'h0, 1'b0);
    rd_check("rst_mepc",     12'h341, 32'h0, 1'b0);
    rd_check("rst_mcause",   12'h342, 32'h0, 1'b0);
    rd_check("rst_mtval",    12'h343, 32'h0, 1'b0);
    rd_check("rst_mip",      12'h344, 32'h0, 1'b0);
    rd_check("rst_mhartid",  12'hF14, HartId, 1'b0);

    // RW / RS / RC on mscratch
    csr_read_addr_ID = 12'h000;
    ex_cmd(2'b01, 1'b1, 12'h340, 32'hA5A5_0000);
    rd_check("rw_mscratch", 12'h340, 32'hA5A5_0000, 1'b0);
    ex_cmd(2'b10, 1'b1, 12'h340, 32'h0000_00FF);
    rd_check("rs_mscratch", 12'h340, 32'hA5A5_00FF, 1'b0);
    ex_cmd(2'b11, 1'b1, 12'h340, 32'hA500_000F);
    rd_check("rc_mscratch", 12'h340, 32'h00A5_00F0, 1'b0);
    ex_cmd(2'b10, 1'b1, 12'h340, 32'h0);
    rd_check("rs0_mscratch", 12'h340, 32'h00A5_00F0, 1'b0);

    // Bypass on mepc with low bits masked
    @(negedge clk);
    csr_read_addr_ID = 12'h341;
    Mask_func_EX     = 2'b01;
    csr_write_en_EX  = 1'b1;
    csr_dest_EX      = 12'h341;
    reg1_or_zimm_EX  = 32'h0000_1237;
    #1;
    check_eq("byp_mepc", csr_out_ID, 32'h0000_1234);
    @(posedge clk);
    #1;
    Mask_func_EX    = 2'b00;
    csr_write_en_EX = 1'b0;
    rd_check("st_mepc", 12'h341, 32'h0000_1234, 1'b0);

    // Field masks on mtvec and mip
    ex_cmd(2'b01, 1'b1, 12'h305, 32'hFFFF_FFFF);
    rd_check("mask_mtvec", 12'h305, 32'hFFFF_FFFD, 1'b0);
    ex_cmd(2'b01, 1'b1, 12'h344, 32'hFFFF_FFFF);
    rd_check("mask_mip", 12'h344, 32'h0000_0888, 1'b0);

    // RC all-ones clears mstatus
    ex_cmd(2'b01, 1'b1, 12'h300, 32'h0000_1888);
    rd_check("rw_mstatus", 12'h300, 32'h0000_1888, 1'b0);
    ex_cmd(2'b11, 1'b1, 12'h300, 32'hFFFF_FFFF);
    rd_check("rc_mstatus", 12'h300, 32'h0, 1'b0);

    // Illegal address and read-only mhartid; dropped writes must not bypass
    ex_cmd(2'b01, 1'b1, 12'h7C0, 32'h0000_DEAD);
    rd_check("ill_7c0", 12'h7C0, 32'h0, 1'b1);
    @(negedge clk);
    csr_read_addr_ID = 12'hF14;
    Mask_func_EX     = 2'b01;
    csr_write_en_EX  = 1'b1;
    csr_dest_EX      = 12'hF14;
    reg1_or_zimm_EX  = 32'h0000_DEAD;
    #1;
    check_eq("ro_hart_byp", csr_out_ID, HartId);
    @(posedge clk);
    #1;
    Mask_func_EX    = 2'b00;
    csr_write_en_EX = 1'b0;
    rd_check("ro_hart", 12'hF14, HartId, 1'b0);

    // Disabled commits leave mie untouched
    ex_cmd(2'b01, 1'b1, 12'h304, 32'h0000_0808);
    ex_cmd(2'b01, 1'b0, 12'h304, 32'h1234_5678);
    rd_check("dis_en", 12'h304, 32'h0000_0808, 1'b0);
    ex_cmd(2'b00, 1'b1, 12'h304, 32'h1234_5678);
    rd_check("dis_func", 12'h304, 32'h0000_0808, 1'b0);

`ifdef CSR_COUNTERS_EN
    // Counter carry, write priority, minstret and bypass
    ex_cmd(2'b01, 1'b1, 12'hB80, 32'h0000_0005);
    ex_cmd(2'b01, 1'b1, 12'hB00, 32'hFFFF_FFFF);
    rd_check("cyc_lo_wr", 12'hB00, 32'hFFFF_FFFF, 1'b0);
    rd_check("cyc_hi_wr", 12'hB80, 32'h0000_0005, 1'b0);
    @(posedge clk);
    #1;
    rd_check("cyc_lo_wrap", 12'hB00, 32'h0, 1'b0);
    rd_check("cyc_hi_carry", 12'hB80, 32'h0000_0006, 1'b0);
    ex_cmd(2'b01, 1'b1, 12'hB00, 32'hFFFF_FFFF);
    ex_cmd(2'b01, 1'b1, 12'hB80, 32'h0);
    rd_check("cyc_hi_prio", 12'hB80, 32'h0, 1'b0);
    rd_check("cyc_lo_cnt", 12'hB00, 32'h0, 1'b0);
    ex_cmd(2'b01, 1'b1, 12'hB02, 32'h0000_000A);
    @(negedge clk);
    instr_retire = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    instr_retire = 1'b0;
    @(posedge clk);
    #1;
    rd_check("instret", 12'hB02, 32'h0000_000D, 1'b0);
    @(negedge clk);
    csr_read_addr_ID = 12'hB82;
    Mask_func_EX     = 2'b01;
    csr_write_en_EX  = 1'b1;
    csr_dest_EX      = 12'hB82;
    reg1_or_zimm_EX  = 32'h0000_0055;
    #1;
    check_eq("byp_instreth", csr_out_ID, 32'h0000_0055);
    @(posedge clk);
    #1;
    Mask_func_EX    = 2'b00;
    csr_write_en_EX = 1'b0;
`else
    // Counters absent
    ex_cmd(2'b01, 1'b1, 12'hB00, 32'h0000_1111);
    rd_check("nocnt_b00", 12'hB00, 32'h0, 1'b1);
    rd_check("nocnt_b80", 12'hB80, 32'h0, 1'b1);
    rd_check("nocnt_b02", 12'hB02, 32'h0, 1'b1);
    rd_check("nocnt_b82", 12'hB82, 32'h0, 1'b1);
`endif

    // Reset in the same cycle as a write: reset wins
    @(negedge clk);
    rst_n           = 1'b0;
    Mask_func_EX    = 2'b01;
    csr_write_en_EX = 1'b1;
    csr_dest_EX     = 12'h304;
    reg1_or_zimm_EX = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    rst_n           = 1'b1;
    Mask_func_EX    = 2'b00;
    csr_write_en_EX = 1'b0;
    rd_check("rst_win_mie", 12'h304, 32'h0, 1'b0);
    rd_check("rst2_mtvec", 12'h305, MtvecRst, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
